// File: rtl/draw_srcbuf_p.sv
`default_nettype none
// ============================================================================
//  Module   : draw_srcbuf_p
//  Purpose  : Source-data buffer for the drawing engine. VRAM read beats
//             flagged as source data are registered in a capture stage and
//             then pushed into a 2^AW-entry FIFO that the draw pipeline reads
//             in strict write order. Status flags are derived from the
//             registered entry count, and one-cycle pulses report rejected
//             writes (overflow) and rejected reads (underflow).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DW               data width in bits (8..256)
//    AW               address width, depth = 2^AW entries (2..12)
//  Ports
//    CLK              clock, all state changes on the rising edge
//    RST_X            asynchronous active-low reset
//    INIT             synchronous clear, overrides all other activity
//    VIF_RDATA        VRAM read data
//    VIF_DRWRDATAVLD  VIF_RDATA valid
//    SRCSEL           beat is source-buffer data
//    BUF_RD           read request
//    AF_THRESH        almost-full threshold (quasi-static)
//    DATA/DATAVALID   read data and its qualifier
//    EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL   status flags
//    DATA_COUNT       number of stored entries (0..2^AW)
//    BUF_OVER         one-cycle pulse: write rejected because buffer full
//    BUF_UNDER        one-cycle pulse: read rejected because buffer empty
//  Configuration
//    DRAW_SRCBUF_FWFT_EN  defined   : first-word-fall-through read port
//                         undefined : registered read port (default)
// ============================================================================
module draw_srcbuf_p #(
  parameter int DW = 64,
  parameter int AW = 9
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          INIT,
  input  logic [DW-1:0] VIF_RDATA,
  input  logic          VIF_DRWRDATAVLD,
  input  logic          SRCSEL,
  input  logic          BUF_RD,
  input  logic [AW:0]   AF_THRESH,
  output logic [DW-1:0] DATA,
  output logic          DATAVALID,
  output logic          EMPTY,
  output logic          ALMOST_EMPTY,
  output logic          FULL,
  output logic          ALMOST_FULL,
  output logic [AW:0]   DATA_COUNT,
  output logic          BUF_OVER,
  output logic          BUF_UNDER
);

  localparam int          c_DEPTH    = 1 << AW;
  // Count value that means "every entry occupied"; one bit wider than the
  // pointers so that full and empty are distinguishable.
  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(c_DEPTH);
  localparam logic [AW:0] c_ONE_CNT  = (AW+1)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DW-1:0] cap_data_q, cap_data_d;
  logic          cap_vld_q,  cap_vld_d;
  logic          cap_sel_q,  cap_sel_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic          over_q,   over_d;
  logic          under_q,  under_d;

  // Storage array; contents are don't-care after reset, so it has no reset.
  logic [DW-1:0] mem_q [c_DEPTH];

  // --------------------------------------------------------------------------
  // Flags: purely a function of the registered count, so they follow reset
  // and INIT automatically without separate clearing.
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;

  assign w_empty      = (count_q == '0);
  assign w_full       = (count_q == c_FULL_CNT);
  assign EMPTY        = w_empty;
  assign FULL         = w_full;
  assign ALMOST_EMPTY = (count_q <= c_ONE_CNT);
  // AF_THRESH = 0 makes this constantly 1, including during reset.
  assign ALMOST_FULL  = (count_q >= AF_THRESH);
  assign DATA_COUNT   = count_q;
  assign BUF_OVER     = over_q;
  assign BUF_UNDER    = under_q;

  // --------------------------------------------------------------------------
  // Request qualification. Both acceptances are judged against the flags as
  // they stand before the edge, so a simultaneous read and write on a full
  // buffer rejects the write even though the read frees a slot.
  // --------------------------------------------------------------------------
  logic w_wr_req;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_wr_req = cap_vld_q & cap_sel_q;
  assign w_wr_acc = w_wr_req & ~w_full  & ~INIT;
  assign w_rd_acc = BUF_RD   & ~w_empty & ~INIT;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cap_data_d = VIF_RDATA;
    cap_vld_d  = VIF_DRWRDATAVLD;
    cap_sel_d  = SRCSEL;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    over_d     = 1'b0;
    under_d    = 1'b0;

    if (INIT) begin
      // Discard the beat sitting in the capture stage and whatever arrives
      // this cycle; ignore BUF_RD; suppress both error pulses.
      cap_data_d = '0;
      cap_vld_d  = 1'b0;
      cap_sel_d  = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      // Pointers are exactly AW bits, so natural overflow wraps modulo the
      // depth and every entry is usable.
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   count_d = count_q + c_ONE_CNT;
        2'b01:   count_d = count_q - c_ONE_CNT;
        default: count_d = count_q;
      endcase

      over_d  = w_wr_req & w_full;
      under_d = BUF_RD   & w_empty;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cap_data_q <= '0;
      cap_vld_q  <= 1'b0;
      cap_sel_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      over_q     <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      cap_data_q <= cap_data_d;
      cap_vld_q  <= cap_vld_d;
      cap_sel_q  <= cap_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      over_q     <= over_d;
      under_q    <= under_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage write: the captured beat lands one edge after it was captured.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_wr_acc) begin
      mem_q[wr_ptr_q] <= cap_data_q;
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
`ifdef DRAW_SRCBUF_FWFT_EN
  // Head entry shown combinationally. Forced to zero while empty so DATA is
  // defined during reset/INIT even though the array itself is never cleared.
  assign DATA      = w_empty ? '0 : mem_q[rd_ptr_q];
  assign DATAVALID = ~w_empty;
`else
  logic [DW-1:0] data_q, data_d;
  logic          dvld_q, dvld_d;

  always_comb begin
    data_d = data_q;       // DATA holds its last value between reads
    dvld_d = 1'b0;
    if (INIT) begin
      data_d = '0;
    end else if (w_rd_acc) begin
      data_d = mem_q[rd_ptr_q];
      dvld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      data_q <= '0;
      dvld_q <= 1'b0;
    end else begin
      data_q <= data_d;
      dvld_q <= dvld_d;
    end
  end

  assign DATA      = data_q;
  assign DATAVALID = dvld_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_draw_srcbuf_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_draw_srcbuf_p
//  Purpose  : Directed self-checking bench for draw_srcbuf_p (DW=64, AW=4).
//             Inputs change 1 time unit after a rising edge and outputs are
//             sampled at that same point, i.e. "after edge k".
//  Revision : 1.0 - initial release
// ============================================================================
module tb_draw_srcbuf_p;

  localparam int DW = 64;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_X;
  logic          INIT;
  logic [DW-1:0] VIF_RDATA;
  logic          VIF_DRWRDATAVLD;
  logic          SRCSEL;
  logic          BUF_RD;
  logic [AW:0]   AF_THRESH;
  logic [DW-1:0] DATA;
  logic          DATAVALID;
  logic          EMPTY;
  logic          ALMOST_EMPTY;
  logic          FULL;
  logic          ALMOST_FULL;
  logic [AW:0]   DATA_COUNT;
  logic          BUF_OVER;
  logic          BUF_UNDER;

  int n_tests = 0;
  int n_fail  = 0;

  draw_srcbuf_p #(.DW(DW), .AW(AW)) u_dut (
    .CLK             (CLK),
    .RST_X           (RST_X),
    .INIT            (INIT),
    .VIF_RDATA       (VIF_RDATA),
    .VIF_DRWRDATAVLD (VIF_DRWRDATAVLD),
    .SRCSEL          (SRCSEL),
    .BUF_RD          (BUF_RD),
    .AF_THRESH       (AF_THRESH),
    .DATA            (DATA),
    .DATAVALID       (DATAVALID),
    .EMPTY           (EMPTY),
    .ALMOST_EMPTY    (ALMOST_EMPTY),
    .FULL            (FULL),
    .ALMOST_FULL     (ALMOST_FULL),
    .DATA_COUNT      (DATA_COUNT),
    .BUF_OVER        (BUF_OVER),
    .BUF_UNDER       (BUF_UNDER)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One beat presented for one edge; valid dropped afterwards.
  task automatic beat(input logic [63:0] d, input logic sel);
    VIF_RDATA       = d;
    VIF_DRWRDATAVLD = 1'b1;
    SRCSEL          = sel;
    tick();
    VIF_DRWRDATAVLD = 1'b0;
    SRCSEL          = 1'b0;
  endtask

  // One accepted read of a known head value; BUF_RD left high for the caller.
  task automatic rd(input string tag, input logic [63:0] exp);
    BUF_RD = 1'b1;
`ifdef DRAW_SRCBUF_FWFT_EN
    check_val({tag, "_data"}, DATA, exp);
    check_val({tag, "_dvld"}, {63'd0, DATAVALID}, 64'd1);
    tick();
`else
    tick();
    check_val({tag, "_data"}, DATA, exp);
    check_val({tag, "_dvld"}, {63'd0, DATAVALID}, 64'd1);
`endif
  endtask

  initial begin
    int exp_cnt;
    int over_seen;

    RST_X = 1'b0; INIT = 1'b0; VIF_RDATA = '0; VIF_DRWRDATAVLD = 1'b0;
    SRCSEL = 1'b0; BUF_RD = 1'b0; AF_THRESH = 5'd0;

    // ---------------- reset state ----------------
    #2;
    check_val("rst_af_thr0", {63'd0, ALMOST_FULL}, 64'd1);
    AF_THRESH = 5'd14;
    #1;
    check_val("rst_af_thr14", {63'd0, ALMOST_FULL}, 64'd0);
    tick(); tick();
    check_val("rst_empty",  {63'd0, EMPTY},        64'd1);
    check_val("rst_aempty", {63'd0, ALMOST_EMPTY}, 64'd1);
    check_val("rst_full",   {63'd0, FULL},         64'd0);
    check_val("rst_count",  {59'd0, DATA_COUNT},   64'd0);
    check_val("rst_data",   DATA,                  64'd0);
    check_val("rst_dvld",   {63'd0, DATAVALID},    64'd0);
    check_val("rst_over",   {63'd0, BUF_OVER},     64'd0);
    check_val("rst_under",  {63'd0, BUF_UNDER},    64'd0);
    RST_X = 1'b1;
    tick();

    // ---------------- write/read latency ----------------
    beat(64'h1111, 1'b1);                 // edge 0: captured only
    check_val("lat_cnt_e0", {59'd0, DATA_COUNT}, 64'd0);
    check_val("lat_emp_e0", {63'd0, EMPTY},      64'd1);
    tick();                               // edge 1: stored
    check_val("lat_cnt_e1", {59'd0, DATA_COUNT}, 64'd1);
    check_val("lat_emp_e1", {63'd0, EMPTY},      64'd0);
`ifdef DRAW_SRCBUF_FWFT_EN
    check_val("lat_fwft_data", DATA, 64'h1111);
    check_val("lat_fwft_dvld", {63'd0, DATAVALID}, 64'd1);
`else
    check_val("lat_std_dvld_e1", {63'd0, DATAVALID}, 64'd0);
`endif
    rd("lat_rd", 64'h1111);               // edge 2
    BUF_RD = 1'b0;
    tick();
`ifndef DRAW_SRCBUF_FWFT_EN
    check_val("lat_dvld_drop", {63'd0, DATAVALID}, 64'd0);
    check_val("lat_data_hold", DATA, 64'h1111);
`endif
    check_val("lat_empty_after", {63'd0, EMPTY}, 64'd1);
    check_val("lat_under_none",  {63'd0, BUF_UNDER}, 64'd0);

    // ---------------- SRCSEL gating ----------------
    over_seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        VIF_RDATA = 64'hA0 + 64'(i); VIF_DRWRDATAVLD = 1'b1; SRCSEL = 1'b0;
      end else begin
        VIF_DRWRDATAVLD = 1'b0;
      end
      tick();
      if (BUF_OVER) over_seen++;
    end
    check_val("sel_count", {59'd0, DATA_COUNT}, 64'd0);
    check_val("sel_over",  64'(over_seen),      64'd0);

    // ---------------- full / overflow ----------------
    // Beat t is presented before edge t; it is stored at edge t+1, so after
    // edge t the count is min(t,16). Beat 16 is rejected at edge 17.
    for (int t = 0; t < 20; t++) begin
      if (t <= 16) begin
        VIF_RDATA = 64'(t); VIF_DRWRDATAVLD = 1'b1; SRCSEL = 1'b1;
      end else begin
        VIF_DRWRDATAVLD = 1'b0; SRCSEL = 1'b0;
      end
      tick();
      exp_cnt = (t < 16) ? t : 16;
      check_val($sformatf("full_cnt_t%0d", t), {59'd0, DATA_COUNT}, 64'(exp_cnt));
      check_val($sformatf("full_af_t%0d", t),  {63'd0, ALMOST_FULL}, 64'(exp_cnt >= 14));
      check_val($sformatf("full_ff_t%0d", t),  {63'd0, FULL},        64'(exp_cnt == 16));
      check_val($sformatf("full_ov_t%0d", t),  {63'd0, BUF_OVER},    64'(t == 17));
    end
    for (int i = 0; i < 16; i++) begin
      rd($sformatf("full_rd%0d", i), 64'(i));
    end
    BUF_RD = 1'b0;
    check_val("full_drained", {59'd0, DATA_COUNT}, 64'd0);
    check_val("full_ae",      {63'd0, ALMOST_EMPTY}, 64'd1);

    // ---------------- underflow ----------------
    BUF_RD = 1'b1;
    tick();
    BUF_RD = 1'b0;
    check_val("und_pulse", {63'd0, BUF_UNDER},   64'd1);
    check_val("und_count", {59'd0, DATA_COUNT},  64'd0);
    tick();
    check_val("und_drop",  {63'd0, BUF_UNDER},   64'd0);

    // ---------------- simultaneous read + write at count 8 ----------------
    for (int i = 0; i < 8; i++) beat(64'h100 + 64'(i), 1'b1);
    tick();
    check_val("sim_cnt8", {59'd0, DATA_COUNT}, 64'd8);
    beat(64'h200, 1'b1);                  // captured; written at next edge
    rd("sim_rd0", 64'h100);               // read and write share this edge
    check_val("sim_cnt_hold", {59'd0, DATA_COUNT}, 64'd8);
    for (int i = 1; i < 8; i++) rd($sformatf("sim_rd%0d", i), 64'h100 + 64'(i));
    rd("sim_rd8", 64'h200);
    BUF_RD = 1'b0;
    check_val("sim_empty", {63'd0, EMPTY}, 64'd1);

    // ---------------- pointer wrap: 40 entries in bursts of 10 ----------------
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) beat(64'h1000 + 64'(b * 10 + i), 1'b1);
      tick();
      for (int i = 0; i < 10; i++) rd($sformatf("wrap_b%0d_%0d", b, i), 64'h1000 + 64'(b * 10 + i));
      BUF_RD = 1'b0;
    end
    check_val("wrap_empty", {63'd0, EMPTY}, 64'd1);

    // ---------------- INIT mid-stream ----------------
    for (int i = 0; i < 6; i++) beat(64'h300 + 64'(i), 1'b1);
    tick();
    check_val("init_cnt6", {59'd0, DATA_COUNT}, 64'd6);
    beat(64'h3FF, 1'b1);                  // now sitting in the capture stage
    INIT = 1'b1; BUF_RD = 1'b1;
    tick();
    INIT = 1'b0; BUF_RD = 1'b0;
    check_val("init_cnt0",  {59'd0, DATA_COUNT}, 64'd0);
    check_val("init_empty", {63'd0, EMPTY},      64'd1);
    check_val("init_under", {63'd0, BUF_UNDER},  64'd0);
    check_val("init_dvld",  {63'd0, DATAVALID},  64'd0);
    check_val("init_data",  DATA,                64'd0);
    tick();
    check_val("init_no_cap", {59'd0, DATA_COUNT}, 64'd0);
    beat(64'h400, 1'b1);
    tick();
    check_val("init_post_cnt", {59'd0, DATA_COUNT}, 64'd1);
    rd("init_post_rd", 64'h400);
    BUF_RD = 1'b0;

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 3; i++) beat(64'h500 + 64'(i), 1'b1);
    tick();
    check_val("arst_pre_cnt", {59'd0, DATA_COUNT}, 64'd3);
    #2 RST_X = 1'b0;
    #1;
    check_val("arst_cnt",   {59'd0, DATA_COUNT}, 64'd0);
    check_val("arst_empty", {63'd0, EMPTY},      64'd1);
    check_val("arst_data",  DATA,                64'd0);
    check_val("arst_over",  {63'd0, BUF_OVER},   64'd0);
    tick();
    RST_X = 1'b1;
    beat(64'h600, 1'b1);
    tick();
    check_val("arst_post_cnt", {59'd0, DATA_COUNT}, 64'd1);
    rd("arst_post_rd", 64'h600);
    BUF_RD = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
